// File: rtl/lr_hs4_sync_bridge.sv
// Bridge from a 4-phase bundled-data REQ/ACK channel into a clocked valid/ready FIFO stream.
// Optional protocol checking (ERR_O) is enabled by defining LR_HS4_PROTOCOL_CHECK_EN.
module lr_hs4_sync_bridge #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       CP,
    input  logic                       RN,
    input  logic                       REQ_I,
    input  logic [WIDTH-1:0]           D_I,
    output logic                       ACK_O,
    output logic                       VALID_O,
    input  logic                       READY_I,
    output logic [WIDTH-1:0]           D_O,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL_O,
`ifdef LR_HS4_PROTOCOL_CHECK_EN
    output logic                       ERR_O,
`endif
    output logic                       o_dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    typedef enum logic {S_IDLE = 1'b0, S_ACK_HI = 1'b1} state_t;

    state_t                 r_state;
    logic                   r_ack;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;

    logic w_req_s;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_err;

    assign w_req_s = r_sync[SYNC_STAGES-1];
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_pop   = (r_level != '0) && READY_I;
    assign w_push  = (r_state == S_IDLE) && w_req_s && !w_full && !w_err;

`ifdef LR_HS4_PROTOCOL_CHECK_EN
    logic r_blocked;
    logic r_disagree;
    logic r_err;
    logic w_withdraw;
    logic w_glitch;

    // A normal REQ edge makes the first two flops disagree for exactly one sample.
    assign w_withdraw = (r_state == S_IDLE) && r_blocked && !w_req_s;
    assign w_glitch   = (r_state == S_ACK_HI) && r_disagree && (r_sync[0] != r_sync[1]);
    assign w_err      = w_withdraw || w_glitch;
    assign ERR_O      = r_err;

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            r_blocked  <= 1'b0;
            r_disagree <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_disagree <= (r_sync[0] != r_sync[1]);
            if (w_err) begin
                r_err <= 1'b1;
            end
            if (r_state == S_IDLE && w_req_s && w_full) begin
                r_blocked <= 1'b1;
            end else if (r_state != S_IDLE || !w_req_s || w_push) begin
                r_blocked <= 1'b0;
            end
        end
    end
`else
    assign w_err = 1'b0;
`endif

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], REQ_I};
        end
    end

    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state <= S_ACK_HI;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK_HI: begin
                    if (!w_req_s || w_err) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    // D_I is only sampled once req_s is high, so the bundling constraint keeps it stable here.
    always_ff @(posedge CP or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= D_I;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign ACK_O       = r_ack;
    assign VALID_O     = (r_level != '0);
    assign D_O         = r_mem[r_rd_ptr];
    assign LEVEL_O     = r_level;
    assign o_dbg_state = (r_state == S_ACK_HI);

endmodule

// File: tb/tb_lr_hs4_sync_bridge.sv
// Bench for lr_hs4_sync_bridge: directed scenarios plus a randomized producer/consumer phase,
// all checked against a token-queue reference model.
module tb_lr_hs4_sync_bridge;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LVL_W       = $clog2(DEPTH+1);

    logic             CP;
    logic             RN;
    logic             REQ_I;
    logic [WIDTH-1:0] D_I;
    logic             ACK_O;
    logic             VALID_O;
    logic             READY_I;
    logic [WIDTH-1:0] D_O;
    logic [LVL_W-1:0] LEVEL_O;
    logic             dbg_state;
`ifdef LR_HS4_PROTOCOL_CHECK_EN
    logic             ERR_O;
`endif

    lr_hs4_sync_bridge #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CP(CP), .RN(RN), .REQ_I(REQ_I), .D_I(D_I), .ACK_O(ACK_O),
        .VALID_O(VALID_O), .READY_I(READY_I), .D_O(D_O), .LEVEL_O(LEVEL_O),
`ifdef LR_HS4_PROTOCOL_CHECK_EN
        .ERR_O(ERR_O),
`endif
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial CP = 1'b0;
    always #5 CP = ~CP;

    // scoreboard state
    logic [WIDTH-1:0] exp_q[$];
    bit               req_hist[$];
    bit               m_ack;
    int               n_tests;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        req_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) req_hist.push_back(1'b0);
        m_ack = 1'b0;
    endtask

    // Advance one clock: model what the edge does, then compare on the falling edge.
    task automatic step();
        bit               r;
        bit               rdy;
        logic [WIDTH-1:0] d;
        bit               req_s;
        bit               pop;
        bit               push;
        r     = REQ_I;
        rdy   = READY_I;
        d     = D_I;
        @(posedge CP);
        req_s = req_hist[SYNC_STAGES-1];
        pop   = (exp_q.size() != 0) && rdy;
        push  = !m_ack && req_s && (exp_q.size() < DEPTH);
        if (m_ack && !req_s) m_ack = 1'b0;
        else if (push)       m_ack = 1'b1;
        req_hist.push_front(r);
        void'(req_hist.pop_back());
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        @(negedge CP);
        check("ack", ACK_O, m_ack);
        check("valid", VALID_O, exp_q.size() != 0);
        check("level", LEVEL_O, exp_q.size());
        if (exp_q.size() != 0) check("dout", D_O, exp_q[0]);
    endtask

    task automatic wait_ack(input bit val, output int n);
        n = 0;
        while (ACK_O !== val && n < 20) begin
            step();
            n++;
        end
        if (ACK_O !== val) check("timeout_ack", ACK_O, val);
    endtask

    task automatic send_token(input logic [WIDTH-1:0] d);
        int n;
        D_I   = d;
        REQ_I = 1'b1;
        wait_ack(1'b1, n);
        REQ_I = 1'b0;
        wait_ack(1'b0, n);
    endtask

    task automatic drain();
        int n;
        READY_I = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check("drain_level", LEVEL_O, 0);
        READY_I = 1'b0;
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        RN      = 1'b0;
        REQ_I   = 1'b1;
        READY_I = 1'b1;
        D_I     = '0;
        reset_model();
        repeat (3) @(negedge CP);
        check("rst_ack", ACK_O, 0);
        check("rst_valid", VALID_O, 0);
        check("rst_level", LEVEL_O, 0);
        check("rst_dout", D_O, 0);

        RN = 1'b1;
        wait_ack(1'b1, n);
        check("rst_rel_lat", n, SYNC_STAGES + 1);
        REQ_I = 1'b0;
        wait_ack(1'b0, n);
        drain();

        // single token
        READY_I = 1'b0;
        D_I     = 8'hA5;
        REQ_I   = 1'b1;
        wait_ack(1'b1, n);
        check("one_rise_lat", n, SYNC_STAGES + 1);
        check("one_valid", VALID_O, 1);
        check("one_dout", D_O, 8'hA5);
        check("one_level", LEVEL_O, 1);
        REQ_I = 1'b0;
        wait_ack(1'b0, n);
        check("one_fall_lat", n, SYNC_STAGES + 1);
        drain();

        // fill and backpressure
        for (int i = 1; i <= 4; i++) send_token(WIDTH'(i));
        check("fill_level", LEVEL_O, 4);
        D_I   = 8'h05;
        REQ_I = 1'b1;
        repeat (6) step();
        check("full_no_ack", ACK_O, 0);
        READY_I = 1'b1;
        step();
        READY_I = 1'b0;
        check("pop_level", LEVEL_O, 3);
        check("pop_head", D_O, 8'h02);
        step();
        check("late_ack", ACK_O, 1);
        check("late_level", LEVEL_O, 4);
        REQ_I   = 1'b0;
        READY_I = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("fill_order", D_O, i);
            step();
        end
        READY_I = 1'b0;
        wait_ack(1'b0, n);
        check("fill_empty", VALID_O, 0);

        // simultaneous push and pop
        send_token(8'h11);
        send_token(8'h22);
        D_I   = 8'h33;
        REQ_I = 1'b1;
        step();
        step();
        READY_I = 1'b1;
        step();
        READY_I = 1'b0;
        check("sim_ack", ACK_O, 1);
        check("sim_level", LEVEL_O, 2);
        check("sim_head", D_O, 8'h22);
        REQ_I = 1'b0;
        wait_ack(1'b0, n);
        drain();

        // randomized producer/consumer, wraps pointers many times
        for (int c = 0; c < 1500; c++) begin
            if (!REQ_I && !ACK_O && $urandom_range(0, 2) == 0) begin
                D_I   = WIDTH'($urandom);
                REQ_I = 1'b1;
            end else if (REQ_I && ACK_O) begin
                REQ_I = 1'b0;
                if ($urandom_range(0, 1) == 1) D_I = WIDTH'($urandom);
            end
            READY_I = ($urandom_range(0, 3) != 0) ? (c % 200 < 120) : ($urandom_range(0, 1) == 1);
            step();
        end
        REQ_I = 1'b0;
        wait_ack(1'b0, n);
        drain();

        // asynchronous reset mid-handshake
        send_token(8'hC1);
        send_token(8'hC2);
        D_I   = 8'hC3;
        REQ_I = 1'b1;
        wait_ack(1'b1, n);
        check("mrst_pre_level", LEVEL_O, 3);
        #2;
        RN = 1'b0;
        #1;
        check("mrst_ack", ACK_O, 0);
        check("mrst_valid", VALID_O, 0);
        check("mrst_level", LEVEL_O, 0);
        REQ_I = 1'b0;
        @(negedge CP);
        RN = 1'b1;
        reset_model();
        repeat (5) step();
        send_token(8'h7E);
        check("post_rst_head", D_O, 8'h7E);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
